fifo_wr_arbiter: RTL

Round-robin, packet-locked arbiter that shares the single write port of a `fifo` instance among `N_REQ` requesters. Each requester presents a valid/ready stream with a `last` marker. The arbiter grants one requester at a time and holds the grant until that requester's packet ends, so packets never interleave in the FIFO. It sits directly in front of the FIFO write side and converts the FIFO's `full` flag into per-requester backpressure.

---
 rtl/fifo_arb_pkg.sv | 17 +
 rtl/rr_picker.sv | 30 +++
 rtl/fifo_wr_arbiter.sv | 93 +++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int N_REQ_DEF  = 4;
  localparam int DATA_W_DEF = 8;

  // Increment an index modulo n (n need not be a power of two).
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set bit of req at or above ptr,
// wrapping from N_REQ-1 back to 0.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             found,
  output logic [ID_W-1:0]  idx
);

  // Walk offsets 0..N_REQ-1 from ptr; the smallest offset with req set wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-locked round-robin arbiter in front of a FIFO write port.
// Handshake: a beat moves when the grantee's req_valid and req_ready are both
// high in the same cycle; req_ready is only ever high for the locked grantee
// and only while the FIFO is not full. Valid may drop mid-packet; the lock
// is held until the beat carrying req_last transfers.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N_REQ  = N_REQ_DEF,
  parameter  int DATA_W = DATA_W_DEF,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_wr_data,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy
);

  arb_state_t      state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic            pick_found;
  logic [ID_W-1:0] pick_idx;
  logic            xfer;

  rr_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_picker (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // State, round-robin pointer and grant registers; async clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
    end
  end

  // Next state: arbitrate in IDLE, release the lock on the last beat.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_id_d = pick_idx;
          state_d    = LOCKED;
        end
      end
      LOCKED: begin
        if (xfer && req_last[grant_id_q]) begin
          rr_ptr_d = ID_W'(wrap_inc(int'(grant_id_q), N_REQ));
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: route the grantee straight through to the FIFO write port.
  always_comb begin
    req_ready    = '0;
    xfer         = 1'b0;
    fifo_wr_data = req_data[grant_id_q*DATA_W +: DATA_W];
    busy         = (state_q == LOCKED);
    if (state_q == LOCKED) begin
      req_ready[grant_id_q] = !fifo_full;
      xfer                  = req_valid[grant_id_q] && !fifo_full;
    end
  end

  assign fifo_wr_en = xfer;
  assign grant_id   = grant_id_q;

endmodule
